// File: rtl/io_responder_pkg.sv
// mapache64 -- shared definitions for the IO responder block.
// Holds the CPU address type, the four IO register addresses, the controller
// button byte layout and the poll FSM state encoding.
// Ports: none (package).
package mapache64;

    typedef logic [15:0] address_t;

    localparam address_t IN_VBLANK_ADDR      = 16'h7000;
    localparam address_t CLR_VBLANK_IRQ_ADDR = 16'h7001;
    localparam address_t CONTROLLER_1_ADDR   = 16'h7002;
    localparam address_t CONTROLLER_2_ADDR   = 16'h7003;

    // Bit 0 is the first button shifted out of the pad after the latch.
    typedef struct packed {
        logic right;
        logic left;
        logic down;
        logic up;
        logic start;
        logic select;
        logic b;
        logic a;
    } controller_state_t;

    typedef enum logic [2:0] {
        POLL_IDLE,
        POLL_LATCH,
        POLL_LOW,
        POLL_HIGH,
        POLL_COMMIT
    } poll_state_t;

    // The four IO registers occupy one aligned 4-byte block.
    function automatic logic is_io_addr(input address_t addr);
        return addr[15:2] == IN_VBLANK_ADDR[15:2];
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// io_responder_if -- CPU bus seen by the IO responder.
// Signals: cpu_address_i (address), cpu_strobe_i (access completes this edge),
// cpu_rwb_i (1 = read), cpu_data_o (read data), cpu_data_oe_o (bus drive).
// Modports: master = CPU side, slave = IO responder side.
interface io_responder_if;
    import mapache64::*;

    address_t   cpu_address_i;
    logic       cpu_strobe_i;
    logic       cpu_rwb_i;
    logic [7:0] cpu_data_o;
    logic       cpu_data_oe_o;

    modport master (
        output cpu_address_i, cpu_strobe_i, cpu_rwb_i,
        input  cpu_data_o, cpu_data_oe_o
    );

    modport slave (
        input  cpu_address_i, cpu_strobe_i, cpu_rwb_i,
        output cpu_data_o, cpu_data_oe_o
    );
endinterface

// File: rtl/io_responder_controller_poller.sv
// controller_poller -- serial game-pad poll sequencer.
// After start_i it pulses the shared latch, clocks eight bits out of each pad,
// samples the (active-low) data lines and publishes both bytes atomically.
// Ports: clk_i, rst_ni (sync, active-low), start_i (begin poll when idle),
//        ctrl_1_data_i / ctrl_2_data_i (serial pad data), ctrl_latch_o,
//        ctrl_clk_o, ctrl_1_state_o / ctrl_2_state_o (committed bytes).
// Macro IO_RESPONDER_CONTROLLER_2_EN adds the controller 2 input and path;
// without it controller 2 reads as all-released.
//
// state  | meaning
// IDLE   | waiting for start_i
// LATCH  | latch high for 2*CTRL_HALF_PERIOD cycles
// LOW    | pad clock low; last cycle samples bit n
// HIGH   | pad clock high, advancing the pads to the next bit
// COMMIT | copy shift registers to the committed bytes
module controller_poller
    import mapache64::*;
#(
    parameter int unsigned CTRL_HALF_PERIOD = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              ctrl_1_data_i,
`ifdef IO_RESPONDER_CONTROLLER_2_EN
    input  logic              ctrl_2_data_i,
`endif
    output logic              ctrl_latch_o,
    output logic              ctrl_clk_o,
    output controller_state_t ctrl_1_state_o,
    output controller_state_t ctrl_2_state_o
);

    localparam logic [8:0] LATCH_LOAD = 9'(2 * CTRL_HALF_PERIOD - 1);
    localparam logic [8:0] HALF_LOAD  = 9'(CTRL_HALF_PERIOD - 1);

    poll_state_t       state_q, state_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    controller_state_t shift_1_q, shift_1_d;
    controller_state_t commit_1_q, commit_1_d;
`ifdef IO_RESPONDER_CONTROLLER_2_EN
    controller_state_t shift_2_q, shift_2_d;
    controller_state_t commit_2_q, commit_2_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= POLL_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_1_q  <= '0;
            commit_1_q <= '0;
`ifdef IO_RESPONDER_CONTROLLER_2_EN
            shift_2_q  <= '0;
            commit_2_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_1_q  <= shift_1_d;
            commit_1_q <= commit_1_d;
`ifdef IO_RESPONDER_CONTROLLER_2_EN
            shift_2_q  <= shift_2_d;
            commit_2_q <= commit_2_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_1_d  = shift_1_q;
        commit_1_d = commit_1_q;
`ifdef IO_RESPONDER_CONTROLLER_2_EN
        shift_2_d  = shift_2_q;
        commit_2_d = commit_2_q;
`endif
        case (state_q)
            POLL_IDLE: begin
                if (start_i) begin
                    state_d = POLL_LATCH;
                    cnt_d   = LATCH_LOAD;
                    bit_d   = '0;
                end
            end
            POLL_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = POLL_LOW;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            POLL_LOW: begin
                if (cnt_q == '0) begin
                    shift_1_d[bit_q] = ~ctrl_1_data_i;
`ifdef IO_RESPONDER_CONTROLLER_2_EN
                    shift_2_d[bit_q] = ~ctrl_2_data_i;
`endif
                    bit_d   = bit_q + 3'd1;
                    cnt_d   = HALF_LOAD;
                    // No trailing clock pulse after the last bit.
                    state_d = (bit_q == 3'd7) ? POLL_COMMIT : POLL_HIGH;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            POLL_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = POLL_LOW;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            POLL_COMMIT: begin
                commit_1_d = shift_1_q;
`ifdef IO_RESPONDER_CONTROLLER_2_EN
                commit_2_d = shift_2_q;
`endif
                state_d    = POLL_IDLE;
            end
            default: state_d = POLL_IDLE;
        endcase
    end

    assign ctrl_latch_o   = (state_q == POLL_LATCH);
    assign ctrl_clk_o     = (state_q == POLL_HIGH);
    assign ctrl_1_state_o = commit_1_q;
`ifdef IO_RESPONDER_CONTROLLER_2_EN
    assign ctrl_2_state_o = commit_2_q;
`else
    assign ctrl_2_state_o = '0;
`endif

endmodule

// File: rtl/io_responder.sv
// io_responder -- memory-mapped IO block at 0x7000..0x7003.
// Decodes the CPU bus, serves zero-latency reads (vblank level, IRQ clear,
// two controller bytes), keeps the vblank IRQ flag and starts a controller
// poll at every vblank.
// Ports: clk_i, rst_ni (sync, active-low), bus (io_responder_if.slave),
//        vblank_start_i, vblank_active_i, cpu_irqb_o (active-low IRQ),
//        ctrl_latch_o, ctrl_clk_o, ctrl_1_data_i, ctrl_2_data_i.
// Macro IO_RESPONDER_CONTROLLER_2_EN enables the controller 2 path; without
// it ctrl_2_data_i is ignored and 0x7003 reads 0x00.
module io_responder
    import mapache64::*;
#(
    parameter int unsigned CTRL_HALF_PERIOD = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    io_responder_if.slave  bus,
    input  logic           vblank_start_i,
    input  logic           vblank_active_i,
    output logic           cpu_irqb_o,
    output logic           ctrl_latch_o,
    output logic           ctrl_clk_o,
    input  logic           ctrl_1_data_i,
    input  logic           ctrl_2_data_i
);

    controller_state_t ctrl_1_state, ctrl_2_state;
    logic              irq_flag_q;

    controller_poller #(
        .CTRL_HALF_PERIOD(CTRL_HALF_PERIOD)
    ) u_poller (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (vblank_start_i),
        .ctrl_1_data_i  (ctrl_1_data_i),
`ifdef IO_RESPONDER_CONTROLLER_2_EN
        .ctrl_2_data_i  (ctrl_2_data_i),
`endif
        .ctrl_latch_o   (ctrl_latch_o),
        .ctrl_clk_o     (ctrl_clk_o),
        .ctrl_1_state_o (ctrl_1_state),
        .ctrl_2_state_o (ctrl_2_state)
    );

`ifndef IO_RESPONDER_CONTROLLER_2_EN
    logic unused_ctrl_2;
    assign unused_ctrl_2 = ctrl_2_data_i;
`endif

    // A new vblank outranks a clear in the same cycle so no IRQ is lost.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_flag_q <= 1'b0;
        end else if (vblank_start_i) begin
            irq_flag_q <= 1'b1;
        end else if (bus.cpu_strobe_i && (bus.cpu_address_i == CLR_VBLANK_IRQ_ADDR)) begin
            irq_flag_q <= 1'b0;
        end
    end

    assign cpu_irqb_o = ~irq_flag_q;

    always_comb begin
        bus.cpu_data_oe_o = bus.cpu_rwb_i && is_io_addr(bus.cpu_address_i);
        bus.cpu_data_o    = 8'h00;
        if (bus.cpu_data_oe_o) begin
            case (bus.cpu_address_i[1:0])
                2'd0:    bus.cpu_data_o = {7'b0, vblank_active_i};
                2'd2:    bus.cpu_data_o = ctrl_1_state;
                2'd3:    bus.cpu_data_o = ctrl_2_state;
                default: bus.cpu_data_o = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic vblank_start = 1'b0;
    logic vblank_active = 1'b0;
    logic irqb, latch, cclk;
    logic c1_data;
    logic c2_data = 1'b0;

    int checks = 0;
    int failures = 0;

    // Pad model: a parallel-in/serial-out shift register. Latch reloads,
    // each rising pad clock advances to the next button; output is active-low.
    logic [7:0] pad1 = 8'h00;
    int         pad_idx = 0;
    logic       cclk_prev = 1'b0;
    logic [7:0] exp_c1 = 8'h00;
    logic [7:0] exp_c2;

    io_responder_if bus ();

    io_responder #(.CTRL_HALF_PERIOD(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bus            (bus),
        .vblank_start_i (vblank_start),
        .vblank_active_i(vblank_active),
        .cpu_irqb_o     (irqb),
        .ctrl_latch_o   (latch),
        .ctrl_clk_o     (cclk),
        .ctrl_1_data_i  (c1_data),
        .ctrl_2_data_i  (c2_data)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (latch) pad_idx <= 0;
        else if (cclk && !cclk_prev) pad_idx <= pad_idx + 1;
        cclk_prev <= cclk;
    end

    assign c1_data = (pad_idx < 8) ? ~pad1[pad_idx[2:0]] : 1'b0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
        bus.cpu_address_i = a;
        bus.cpu_rwb_i     = 1'b1;
        bus.cpu_strobe_i  = 1'b0;
        #1;
        d  = bus.cpu_data_o;
        oe = bus.cpu_data_oe_o;
    endtask

    // Leaves the bench just after the edge that samples the pulse (cycle 0).
    task automatic pulse_vblank();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
    endtask

    // A full poll is 69 cycles; after it the committed byte equals the pad.
    task automatic finish_poll();
        repeat (75) tick();
        exp_c1 = pad1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic oe;
        rst_ni = 1'b0;
        repeat (3) tick();
        checks++; if (irqb !== 1'b1) begin failures++; $display("FAIL reset_irqb: got %b want 1", irqb); end
        checks++; if (latch !== 1'b0) begin failures++; $display("FAIL reset_latch: got %b want 0", latch); end
        checks++; if (cclk !== 1'b0) begin failures++; $display("FAIL reset_clk: got %b want 0", cclk); end
        bus_read(16'h7002, d, oe);
        checks++; if ({oe, d} !== 9'h100) begin failures++; $display("FAIL reset_c1: got oe=%b d=%h want oe=1 d=00", oe, d); end
        rst_ni = 1'b1;
        tick();
        vblank_active = 1'b1;
        bus_read(16'h7000, d, oe);
        checks++; if ({oe, d} !== 9'h101) begin failures++; $display("FAIL in_vblank_hi: got oe=%b d=%h want oe=1 d=01", oe, d); end
        vblank_active = 1'b0;
        bus_read(16'h7000, d, oe);
        checks++; if ({oe, d} !== 9'h100) begin failures++; $display("FAIL in_vblank_lo: got oe=%b d=%h want oe=1 d=00", oe, d); end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        logic oe;
        pulse_vblank();
        checks++; if (irqb !== 1'b0) begin failures++; $display("FAIL irq_set: got %b want 0", irqb); end
        bus_read(16'h7001, d, oe);
        bus.cpu_strobe_i = 1'b1;
        #1;
        checks++; if ({oe, d} !== 9'h100) begin failures++; $display("FAIL clr_read_data: got oe=%b d=%h want oe=1 d=00", oe, d); end
        tick();
        bus.cpu_strobe_i = 1'b0;
        checks++; if (irqb !== 1'b1) begin failures++; $display("FAIL irq_clr_read: got %b want 1", irqb); end
        finish_poll();
    endtask

    task automatic test_irq_set_wins();
        logic [7:0] d;
        logic oe;
        bus.cpu_address_i = 16'h7001;
        bus.cpu_rwb_i     = 1'b0;
        bus.cpu_strobe_i  = 1'b1;
        vblank_start      = 1'b1;
        tick();
        vblank_start     = 1'b0;
        bus.cpu_strobe_i = 1'b0;
        tick();
        checks++; if (irqb !== 1'b0) begin failures++; $display("FAIL irq_set_wins: got %b want 0", irqb); end
        finish_poll();
        // Writes to the other IO registers must neither clear the IRQ nor alter data.
        for (int i = 0; i < 3; i++) begin
            bus.cpu_address_i = (i == 0) ? 16'h7000 : (i == 1) ? 16'h7002 : 16'h7003;
            bus.cpu_rwb_i     = 1'b0;
            bus.cpu_strobe_i  = 1'b1;
            tick();
            bus.cpu_strobe_i  = 1'b0;
        end
        checks++; if (irqb !== 1'b0) begin failures++; $display("FAIL ignored_write_irq: got %b want 0", irqb); end
        bus_read(16'h7002, d, oe);
        checks++; if (d !== exp_c1) begin failures++; $display("FAIL ignored_write_c1: got %h want %h", d, exp_c1); end
        bus.cpu_address_i = 16'h7001;
        bus.cpu_rwb_i     = 1'b0;
        bus.cpu_strobe_i  = 1'b1;
        tick();
        bus.cpu_strobe_i  = 1'b0;
        checks++; if (irqb !== 1'b1) begin failures++; $display("FAIL irq_clr_write: got %b want 1", irqb); end
    endtask

    task automatic run_poll_check(input logic [7:0] buttons, input string name);
        logic [7:0] d;
        logic oe;
        pad1 = buttons;
        pulse_vblank();
        repeat (68) tick();
        bus_read(16'h7002, d, oe);
        checks++; if (d !== exp_c1) begin failures++; $display("FAIL %s_c68: got %h want %h", name, d, exp_c1); end
        tick();
        bus_read(16'h7002, d, oe);
        checks++; if (d !== buttons) begin failures++; $display("FAIL %s_c69: got %h want %h", name, d, buttons); end
        exp_c1 = buttons;
        repeat (6) tick();
    endtask

    task automatic test_poll_pattern();
        run_poll_check(8'h5A, "pattern");
        for (int i = 0; i < 5; i++) run_poll_check(8'($urandom), "random");
    endtask

    task automatic test_no_restart();
        logic [7:0] d;
        logic oe;
        logic [7:0] buttons;
        buttons = 8'($urandom) ^ exp_c1;
        if (buttons == exp_c1) buttons = ~exp_c1;
        pad1 = buttons;
        pulse_vblank();
        repeat (19) tick();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        checks++; if (latch !== 1'b0) begin failures++; $display("FAIL no_restart_latch: got %b want 0", latch); end
        repeat (48) tick();
        bus_read(16'h7002, d, oe);
        checks++; if (d !== exp_c1) begin failures++; $display("FAIL no_restart_c68: got %h want %h", d, exp_c1); end
        tick();
        bus_read(16'h7002, d, oe);
        checks++; if (d !== buttons) begin failures++; $display("FAIL no_restart_c69: got %h want %h", d, buttons); end
        exp_c1 = buttons;
        repeat (10) tick();
        checks++; if (latch !== 1'b0) begin failures++; $display("FAIL no_restart_idle: got %b want 0", latch); end
        bus.cpu_address_i = 16'h7001;
        bus.cpu_strobe_i  = 1'b1;
        tick();
        bus.cpu_strobe_i  = 1'b0;
    endtask

    task automatic test_reset_mid_poll();
        logic [7:0] d;
        logic oe;
        pad1 = 8'($urandom) | 8'h01;
        pulse_vblank();
        repeat (29) tick();
        rst_ni = 1'b0;
        tick();
        checks++; if ({latch, cclk} !== 2'b00) begin failures++; $display("FAIL midrst_pins: got latch=%b clk=%b want 0 0", latch, cclk); end
        bus_read(16'h7002, d, oe);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL midrst_c1: got %h want 00", d); end
        checks++; if (irqb !== 1'b1) begin failures++; $display("FAIL midrst_irqb: got %b want 1", irqb); end
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (60) tick();
        bus_read(16'h7002, d, oe);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL midrst_no_commit: got %h want 00", d); end
        exp_c1 = 8'h00;
    endtask

    task automatic test_decode();
        logic [7:0] d;
        logic oe;
        logic [15:0] a;
        bus_read(16'h6FFF, d, oe);
        checks++; if ({oe, d} !== 9'h000) begin failures++; $display("FAIL dec_6fff: got oe=%b d=%h want oe=0 d=00", oe, d); end
        bus_read(16'h7004, d, oe);
        checks++; if ({oe, d} !== 9'h000) begin failures++; $display("FAIL dec_7004: got oe=%b d=%h want oe=0 d=00", oe, d); end
        vblank_active = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            if (a[15:2] == 14'h1C00) a = 16'h8000;
            bus_read(a, d, oe);
            checks++; if ({oe, d} !== 9'h000) begin failures++; $display("FAIL dec_rand %h: got oe=%b d=%h want oe=0 d=00", a, oe, d); end
        end
        bus.cpu_address_i = 16'h7000;
        bus.cpu_rwb_i     = 1'b0;
        #1;
        checks++; if ({bus.cpu_data_oe_o, bus.cpu_data_o} !== 9'h000) begin failures++; $display("FAIL dec_write_oe: got oe=%b d=%h want oe=0 d=00", bus.cpu_data_oe_o, bus.cpu_data_o); end
        vblank_active = 1'b0;
    endtask

    task automatic test_controller_2();
        logic [7:0] d;
        logic oe;
        c2_data = 1'b0;
        pulse_vblank();
        finish_poll();
`ifdef IO_RESPONDER_CONTROLLER_2_EN
        exp_c2 = 8'hFF;
`else
        exp_c2 = 8'h00;
`endif
        bus_read(16'h7003, d, oe);
        checks++; if ({oe, d} !== {1'b1, exp_c2}) begin failures++; $display("FAIL c2_read: got oe=%b d=%h want oe=1 d=%h", oe, d, exp_c2); end
        bus_read(16'h7002, d, oe);
        checks++; if (d !== exp_c1) begin failures++; $display("FAIL c1_after_c2: got %h want %h", d, exp_c1); end
    endtask

    initial begin
        bus.cpu_address_i = 16'h0000;
        bus.cpu_rwb_i     = 1'b1;
        bus.cpu_strobe_i  = 1'b0;
        test_reset();
        test_irq();
        test_irq_set_wins();
        test_poll_pattern();
        test_no_restart();
        test_reset_mid_poll();
        test_decode();
        test_controller_2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter CTRL_HALF_PERIOD, default 4: controller clock half-period in clk_i cycles, legal range 1..255.
REQ-002 SHALL have port clk_i, input, 1: the single system clock.
REQ-003 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port cpu_address_i, input, mapache64::address_t (16): the CPU address.
REQ-005 SHALL have port cpu_strobe_i, input, 1: a CPU bus access completes at this clock edge.
REQ-006 SHALL have port cpu_rwb_i, input, 1: 1 = read, 0 = write.
REQ-007 SHALL have port cpu_data_o, input/output n/a, output, 8: the read data.
REQ-008 SHALL have port cpu_data_oe_o, output, 1: the block drives the data bus.
REQ-009 SHALL have port vblank_start_i, input, 1: one-cycle pulse at the start of vblank.
REQ-010 SHALL have port vblank_active_i, input, 1: level, high during vblank.
REQ-011 SHALL have port cpu_irqb_o, output, 1: active-low vblank IRQ.
REQ-012 SHALL have port ctrl_latch_o, output, 1: shared controller latch.
REQ-013 SHALL have port ctrl_clk_o, output, 1: shared controller clock.
REQ-014 SHALL have ports ctrl_1_data_i and ctrl_2_data_i, input, 1 each: serial data, active-low (pressed = 0).

Function
REQ-015 SHALL decode 0x7000 (IN_VBLANK), 0x7001 (CLR_VBLANK_IRQ), 0x7002 (CONTROLLER_1) and 0x7003 (CONTROLLER_2); all other addresses are ignored.
REQ-016 SHALL assert cpu_data_oe_o combinationally when cpu_rwb_i=1 and the address is one of the four IO addresses, independent of cpu_strobe_i.
REQ-017 SHALL return read data combinationally, with zero latency: 0x7000 -> {7'b0, vblank_active_i}; 0x7001 -> 0x00; 0x7002/0x7003 -> the committed controller byte. When cpu_data_oe_o=0, cpu_data_o SHALL be 0x00.
REQ-018 SHALL set the IRQ flag on vblank_start_i; cpu_irqb_o = ~flag.
REQ-019 SHALL clear the IRQ flag on any strobed access (read or write) to 0x7001; if set and clear occur in the same cycle, the set SHALL win.
REQ-020 SHALL ignore writes to 0x7000, 0x7002 and 0x7003.
REQ-021 SHALL implement the poll FSM: IDLE -> LATCH -> LOW -> HIGH -> LOW ... -> COMMIT -> IDLE.
REQ-022 SHALL leave IDLE on vblank_start_i. vblank_start_i outside IDLE SHALL NOT restart the poll.
REQ-023 LATCH SHALL hold ctrl_latch_o=1 for 2*CTRL_HALF_PERIOD cycles.
REQ-024 LOW SHALL hold ctrl_clk_o=0 for CTRL_HALF_PERIOD cycles and sample both data lines, inverted, on its last cycle into bit n (bit 0 first), with n from a 3-bit counter.
REQ-025 HIGH SHALL hold ctrl_clk_o=1 for CTRL_HALF_PERIOD cycles; the transition after the bit-7 sample SHALL go to COMMIT, not HIGH.
REQ-026 COMMIT SHALL copy both shift registers into the committed bytes in one cycle, so reads never see a partial byte.
REQ-027 The committed bytes SHALL update exactly 17*CTRL_HALF_PERIOD+1 cycles after the vblank_start_i cycle.

Reset
REQ-028 While rst_ni=0 at a clock edge: FSM=IDLE, counters=0, shift and committed bytes=0x00, IRQ flag=0.
REQ-029 Reset values of outputs: cpu_irqb_o=1, ctrl_latch_o=0, ctrl_clk_o=0; cpu_data_o/cpu_data_oe_o follow REQ-016/017 with zeroed state.
REQ-030 Reset mid-poll SHALL abort with no commit; the previously committed bytes are cleared to 0x00.

Configuration
REQ-031 Macro IO_RESPONDER_CONTROLLER_2_EN: when defined, the controller 2 path SHALL be per REQ-024..026; when undefined, ctrl_2_data_i SHALL be unused, no controller 2 shift register SHALL exist, and reads of 0x7003 SHALL return 0x00 with cpu_data_oe_o still asserted.

Structure
REQ-032 Package mapache64 SHALL hold the IO address constants (IN_VBLANK_ADDR..CONTROLLER_2_ADDR) and the typedef controller_state_t (8-bit packed struct, bit 0 = first shifted button).
REQ-033 The poll FSM plus shift registers SHALL be sub-module controller_poller; io_responder holds the decode, the read mux and the IRQ flag.

Verification
REQ-034 Reset, then CTRL_HALF_PERIOD=4, pulse vblank_start_i -> cpu_irqb_o=0 next cycle; strobed read of 0x7001 -> cpu_data_o=0x00, cpu_irqb_o=1 next cycle.
REQ-035 vblank_start_i and a strobed write to 0x7001 in the same cycle -> cpu_irqb_o=0 afterwards.
REQ-036 Controller 1 line drives pattern 0b10100101 (LSB first, active-low) -> 0x7002 reads 0x5A at cycle 69, and the old value at cycle 68.
REQ-037 Second vblank_start_i at cycle 20 of a poll -> no restart; the commit still occurs at cycle 69 from the first pulse.
REQ-038 rst_ni=0 at cycle 30 of a poll -> latch/clock low, 0x7002 reads 0x00, and no commit occurs.
REQ-039 With IO_RESPONDER_CONTROLLER_2_EN undefined and ctrl_2_data_i=0 -> 0x7003 reads 0x00; a read of 0x6FFF -> cpu_data_oe_o=0.
